perceptron_stream_core: RTL and testbench
=========================================

// Module: perceptron_stream_core
// PURPOSE
//   Parametrised N-input perceptron engine behind a byte-stream command port; next generation of the
//   fixed UART perceptron top. Driven by the existing UART rx/tx byte modules. Loads signed 8-bit weights and bias,
//   runs a sequential MAC with one product per cycle, and replies with a step or saturated raw result.
//   Adds frame timeout, NAK and overrun reporting.
// PARAMETERS
//   N_INPUTS        4         number of inputs/weights, 1..64
//   OUT_MODE        0         0: reply 0x01 if sum>=0 else 0x00; 1: reply sum saturated to signed 8-bit
//   TIMEOUT_CYCLES  12000000  max clk cycles between bytes inside a frame (1 s @ 12 MHz)
//   ACC_W           derived   16 + clog2(N_INPUTS) + 1, signed accumulator width
// PORTS
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   rx_data     in   8  received byte, valid when rx_valid=1
//   rx_valid    in   1  one-cycle strobe per received byte
//   tx_data     out  8  reply byte
//   tx_valid    out  1  reply byte available; held until tx_ready
//   tx_ready    in   1  UART tx accepts byte when tx_valid&tx_ready
//   busy        out  1  high in every state except IDLE
//   rx_overrun  out  1  sticky: a byte arrived in MAC/RESP and was dropped
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, all weights/bias=0, acc=0, counters=0, tx_valid=0, tx_data=0,
//     busy=0, rx_overrun=0. Reset mid-frame discards the frame and sends no reply.
//   Frame protocol (bytes on rx_data):
//     0x57 'W' + N_INPUTS weight bytes + 1 bias byte -> reply 0x06 (ACK).
//     0x45 'E' + N_INPUTS input bytes -> reply one result byte.
//     Any other command byte -> reply 0x15 (NAK).
//   FSM: IDLE -> LOAD_W ('W') | LOAD_X ('E') | RESP with NAK (other byte).
//     LOAD_W: bytes go into a shadow weight array with index 0..N-1, then the bias. On the bias byte,
//       shadow is committed to active weights and bias in one cycle -> RESP(ACK).
//     LOAD_X: bytes go into input regs, index 0..N-1. On byte N-1 -> MAC.
//     MAC: on entry acc = sign-extended bias; for N cycles acc += w[i]*x[i] (signed 8x8 -> 16, sign-extended
//       to ACC_W, no overflow possible). Then -> RESP(result).
//     RESP: tx_valid=1, tx_data stable; on tx_valid&tx_ready -> IDLE and tx_valid=0 in the next cycle.
//   Latency: last input byte strobed in cycle T -> MAC in cycles T+1..T+N -> tx_valid=1 from T+N+1.
//   OUT_MODE 1: tx_data = acc clamped to [-128,127] (two's complement).
//   Timeout: in LOAD_W/LOAD_X a counter resets on each rx_valid. When it reaches TIMEOUT_CYCLES:
//     abort -> RESP(NAK). Active weights/bias are unchanged, so a partial 'W' frame never corrupts them.
//   rx_valid in MAC or RESP: byte dropped and rx_overrun set (cleared only by reset). rx_valid in IDLE in the
//     same cycle as leaving RESP is treated as a new command byte.
//   tx_ready is ignored while tx_valid=0. Only one reply is ever outstanding.
//   N_INPUTS=1: LOAD_X lasts one byte, MAC one cycle.
//   Index counters never wrap: the transition fires exactly at N-1.
// TESTING
//   1 Reset: after rst_n release, 'E' {0,0,0,0} -> reply 0x01 (bias 0, sum 0 >= 0).
//   2 'W' {1,2,3,4} bias 0xF6(-10) -> 0x06.
//     Then 'E' {1,1,1,1} -> 0x01 (sum 0); 'E' {0xFF,0,0,0} -> 0x00 (sum -11).
//   3 OUT_MODE=1, 'W' {127,127,127,127} bias 0, 'E' {127,127,127,127} -> 0x7F (saturated).
//     'E' {0x80,0,0,0} -> 0x80 (-16256 clamped).
//   4 Command byte 0x41 -> 0x15 NAK, busy back to 0. Then a valid 'E' frame is answered normally.
//   5 TIMEOUT_CYCLES=100: 'W' + 2 bytes, then idle 100 cycles -> NAK.
//     Next 'E' {1,1,1,1} uses the old weights/bias.
//   6 Hold tx_ready=0 for 50 cycles in RESP: tx_valid/tx_data stable. Byte sent during MAC -> rx_overrun=1,
//     reply unaffected. Assert rst_n=0 during LOAD_X -> all outputs at reset values immediately.

Source files
------------

// File: rtl/perceptron_stream_core.sv
// perceptron_stream_core
// N-input perceptron engine behind a byte-stream command port.
//   'W' + N weights + bias -> ACK (0x06), weights committed atomically on the bias byte
//   'E' + N inputs         -> one result byte after an N-cycle sequential MAC
//   anything else          -> NAK (0x15)
// A silent gap of TIMEOUT_CYCLES inside a frame aborts it with a NAK.
// Bytes arriving while computing or replying are dropped and flagged in rx_overrun.
//
// state  | meaning
// IDLE   | waiting for a command byte
// LOAD_W | collecting weight bytes into the shadow array, then the bias byte
// LOAD_X | collecting input bytes
// MAC    | one signed product accumulated per cycle
// RESP   | reply byte held on tx_data until tx_ready
module perceptron_stream_core #(
  parameter int N_INPUTS       = 4,
  parameter int OUT_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       rx_overrun
);

  localparam int ACC_W = 16 + $clog2(N_INPUTS) + 1;
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
  // The counter is reloaded on every byte and expires when it reaches zero,
  // so the abort fires after exactly TIMEOUT_CYCLES quiet cycles.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_E   = 8'h45;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_MAC,
    S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      bias_ph_q, bias_ph_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      tx_valid_q, tx_valid_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      overrun_q, overrun_d;

  logic [7:0]                wsh_q [N_INPUTS];
  logic [7:0]                w_q   [N_INPUTS];
  logic [7:0]                x_q   [N_INPUTS];
  logic [7:0]                bias_q;

  logic                      wsh_we;
  logic                      x_we;
  logic                      commit;
  logic signed [15:0]        prod;
  logic signed [ACC_W-1:0]   sum;

  function automatic logic [7:0] reply_byte(input logic signed [ACC_W-1:0] s);
    if (OUT_MODE == 0) return s[ACC_W-1] ? 8'h00 : 8'h01;
    if (s > SAT_MAX) return 8'h7F;
    if (s < SAT_MIN) return 8'h80;
    return s[7:0];
  endfunction

  // Next-state, counters and reply generation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bias_ph_d  = bias_ph_q;
    tmo_d      = tmo_q;
    acc_d      = acc_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    overrun_d  = overrun_q;
    wsh_we     = 1'b0;
    x_we       = 1'b0;
    commit     = 1'b0;
    prod       = $signed(w_q[idx_q]) * $signed(x_q[idx_q]);
    sum        = acc_q + {{(ACC_W-16){prod[15]}}, prod};

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          idx_d     = '0;
          bias_ph_d = 1'b0;
          tmo_d     = TMO_LOAD;
          if (rx_data == CMD_W) begin
            state_d = S_LOAD_W;
          end else if (rx_data == CMD_E) begin
            state_d = S_LOAD_X;
          end else begin
            tx_data_d  = RSP_NAK;
            tx_valid_d = 1'b1;
            state_d    = S_RESP;
          end
        end
      end

      S_LOAD_W: begin
        if (rx_valid) begin
          tmo_d = TMO_LOAD;
          if (bias_ph_q) begin
            commit     = 1'b1;
            tx_data_d  = RSP_ACK;
            tx_valid_d = 1'b1;
            state_d    = S_RESP;
          end else begin
            wsh_we = 1'b1;
            if (idx_q == LAST_IDX) bias_ph_d = 1'b1;
            else                   idx_d     = idx_q + IDX_W'(1);
          end
        end else if (tmo_q == '0) begin
          tx_data_d  = RSP_NAK;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end

      S_LOAD_X: begin
        if (rx_valid) begin
          tmo_d = TMO_LOAD;
          x_we  = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            acc_d   = {{(ACC_W-8){bias_q[7]}}, bias_q};
            state_d = S_MAC;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (tmo_q == '0) begin
          tx_data_d  = RSP_NAK;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end

      S_MAC: begin
        if (rx_valid) overrun_d = 1'b1;
        acc_d = sum;
        if (idx_q == LAST_IDX) begin
          tx_data_d  = reply_byte(sum);
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_RESP: begin
        if (rx_valid) overrun_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      bias_ph_q  <= 1'b0;
      tmo_q      <= '0;
      acc_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bias_ph_q  <= bias_ph_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      overrun_q  <= overrun_d;
    end
  end

  // Weight, bias and input storage; active weights change only on a complete 'W' frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        wsh_q[i] <= '0;
        w_q[i]   <= '0;
        x_q[i]   <= '0;
      end
      bias_q <= '0;
    end else begin
      if (wsh_we) wsh_q[idx_q] <= rx_data;
      if (x_we)   x_q[idx_q]   <= rx_data;
      if (commit) begin
        for (int i = 0; i < N_INPUTS; i++) w_q[i] <= wsh_q[i];
        bias_q <= rx_data;
      end
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_perceptron_stream_core.sv
// Directed bench: two instances (step output and saturated output) share one
// byte stream, so every reply is checked in both output modes.
module tb_perceptron_stream_core;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_E = 8'h45;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_valid0, tx_valid1;
  logic       busy0, busy1;
  logic       ovr0, ovr1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perceptron_stream_core #(.N_INPUTS(4), .OUT_MODE(0), .TIMEOUT_CYCLES(100)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
    .busy(busy0), .rx_overrun(ovr0)
  );

  perceptron_stream_core #(.N_INPUTS(4), .OUT_MODE(1), .TIMEOUT_CYCLES(100)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
    .busy(busy1), .rx_overrun(ovr1)
  );

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send_byte(cmd);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    send_byte(d);
  endtask

  // Returns the number of negedges from the current one until tx_valid, capped at 300.
  task automatic wait_reply(output int lat);
    lat = 0;
    while (tx_valid0 !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid0, tx_data0, busy0, ovr0} !== 11'b0)
      begin errors++; $display("FAIL reset_outputs_m0: got %b expected 0", {tx_valid0, tx_data0, busy0, ovr0}); end
    checks++;
    if ({tx_valid1, tx_data1, busy1, ovr1} !== 11'b0)
      begin errors++; $display("FAIL reset_outputs_m1: got %b expected 0", {tx_valid1, tx_data1, busy1, ovr1}); end
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(CMD_E, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_reply(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL reset_eval_latency: got %0d expected 4", lat); end
    checks++;
    if (tx_data0 !== 8'h01) begin errors++; $display("FAIL reset_eval_m0: got %h expected 01", tx_data0); end
    checks++;
    if (tx_data1 !== 8'h00) begin errors++; $display("FAIL reset_eval_m1: got %h expected 00", tx_data1); end
    @(negedge clk);
    checks++;
    if (tx_valid0 !== 1'b0 || busy0 !== 1'b0)
      begin errors++; $display("FAIL reset_eval_release: tx_valid=%b busy=%b expected 0 0", tx_valid0, busy0); end
  endtask

  task automatic test_weights();
    int lat;
    logic [7:0] xv [2][4];
    logic [7:0] e0 [2];
    logic [7:0] e1 [2];
    xv[0] = '{8'h01, 8'h01, 8'h01, 8'h01}; e0[0] = 8'h01; e1[0] = 8'h00;  // 1+2+3+4-10 = 0
    xv[1] = '{8'hFF, 8'h00, 8'h00, 8'h00}; e0[1] = 8'h00; e1[1] = 8'hF5;  // -1-10 = -11
    send_frame(CMD_W, 8'd1, 8'd2, 8'd3, 8'd4);
    send_byte(8'hF6);
    wait_reply(lat);
    checks++;
    if (tx_valid0 !== 1'b1 || tx_data0 !== 8'h06 || tx_data1 !== 8'h06)
      begin errors++; $display("FAIL weights_ack: got %h/%h valid=%b expected 06/06", tx_data0, tx_data1, tx_valid0); end
    @(negedge clk);
    for (int v = 0; v < 2; v++) begin
      send_frame(CMD_E, xv[v][0], xv[v][1], xv[v][2], xv[v][3]);
      wait_reply(lat);
      checks++;
      if (tx_valid0 !== 1'b1 || tx_data0 !== e0[v] || tx_data1 !== e1[v])
        begin errors++; $display("FAIL weights_eval%0d: got %h/%h expected %h/%h", v, tx_data0, tx_data1, e0[v], e1[v]); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    int lat;
    send_frame(CMD_W, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    send_byte(8'h00);
    wait_reply(lat);
    @(negedge clk);
    send_frame(CMD_E, 8'h7F, 8'h7F, 8'h7F, 8'h7F);  // +64516
    wait_reply(lat);
    checks++;
    if (tx_data0 !== 8'h01 || tx_data1 !== 8'h7F)
      begin errors++; $display("FAIL sat_pos: got %h/%h expected 01/7f", tx_data0, tx_data1); end
    @(negedge clk);
    send_frame(CMD_E, 8'h80, 8'h00, 8'h00, 8'h00);  // -16256
    wait_reply(lat);
    checks++;
    if (tx_data0 !== 8'h00 || tx_data1 !== 8'h80)
      begin errors++; $display("FAIL sat_neg: got %h/%h expected 00/80", tx_data0, tx_data1); end
    @(negedge clk);
  endtask

  task automatic test_nak();
    int lat;
    send_byte(8'h41);
    wait_reply(lat);
    checks++;
    if (tx_valid0 !== 1'b1 || tx_data0 !== 8'h15 || tx_data1 !== 8'h15)
      begin errors++; $display("FAIL nak_reply: got %h/%h valid=%b expected 15/15", tx_data0, tx_data1, tx_valid0); end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0)
      begin errors++; $display("FAIL nak_busy: got %b/%b expected 0/0", busy0, busy1); end
    send_frame(CMD_E, 8'h01, 8'h01, 8'h01, 8'h01);  // 4*127 = 508
    wait_reply(lat);
    checks++;
    if (tx_data0 !== 8'h01 || tx_data1 !== 8'h7F)
      begin errors++; $display("FAIL nak_then_eval: got %h/%h expected 01/7f", tx_data0, tx_data1); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    send_frame(CMD_W, 8'd1, 8'd2, 8'd3, 8'd4);
    send_byte(8'hF6);
    wait_reply(lat);
    @(negedge clk);
    send_byte(CMD_W);
    send_byte(8'h05);
    send_byte(8'h05);
    wait_reply(lat);
    checks++;
    if (lat < 100 || lat > 101)
      begin errors++; $display("FAIL timeout_delay: got %0d cycles expected 100..101", lat); end
    checks++;
    if (tx_valid0 !== 1'b1 || tx_data0 !== 8'h15 || tx_data1 !== 8'h15)
      begin errors++; $display("FAIL timeout_nak: got %h/%h expected 15/15", tx_data0, tx_data1); end
    @(negedge clk);
    send_frame(CMD_E, 8'h01, 8'h01, 8'h01, 8'h01);  // old weights: 0
    wait_reply(lat);
    checks++;
    if (tx_data0 !== 8'h01 || tx_data1 !== 8'h00)
      begin errors++; $display("FAIL timeout_old_weights: got %h/%h expected 01/00", tx_data0, tx_data1); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    tx_ready = 1'b0;
    send_frame(CMD_E, 8'h02, 8'h00, 8'h00, 8'h00);  // 2-10 = -8
    send_byte(CMD_E);
    checks++;
    if (ovr0 !== 1'b1 || ovr1 !== 1'b1)
      begin errors++; $display("FAIL overrun_flag: got %b/%b expected 1/1", ovr0, ovr1); end
    wait_reply(lat);
    checks++;
    if (tx_valid0 !== 1'b1 || tx_data0 !== 8'h00 || tx_data1 !== 8'hF8)
      begin errors++; $display("FAIL overrun_reply: got %h/%h expected 00/f8", tx_data0, tx_data1); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid0 !== 1'b1 || tx_valid1 !== 1'b1 || tx_data0 !== 8'h00 || tx_data1 !== 8'hF8) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable: %0d unstable cycles expected 0", bad); end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid0 !== 1'b0 || busy0 !== 1'b0 || ovr0 !== 1'b1)
      begin errors++; $display("FAIL hold_release: valid=%b busy=%b ovr=%b expected 0 0 1", tx_valid0, busy0, ovr0); end
  endtask

  task automatic test_reset_midframe();
    int lat;
    send_byte(CMD_E);
    send_byte(8'h03);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid0, tx_data0, busy0, ovr0, tx_valid1, tx_data1, busy1, ovr1} !== 22'b0)
      begin errors++; $display("FAIL midframe_reset: busy=%b/%b ovr=%b/%b expected all 0", busy0, busy1, ovr0, ovr1); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_valid0 !== 1'b0 || busy0 !== 1'b0)
      begin errors++; $display("FAIL midframe_no_reply: valid=%b busy=%b expected 0 0", tx_valid0, busy0); end
    send_frame(CMD_E, 8'h02, 8'h00, 8'h00, 8'h00);  // cleared weights: 0
    wait_reply(lat);
    checks++;
    if (tx_data0 !== 8'h01 || tx_data1 !== 8'h00)
      begin errors++; $display("FAIL midframe_cleared_weights: got %h/%h expected 01/00", tx_data0, tx_data1); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_weights();
    test_saturate();
    test_nak();
    test_timeout();
    test_backpressure();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
